// File: rtl/cpu_pkg.sv
// Shared constants and loader state encoding for the 4-bit CPU program path.
package cpu_pkg;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      DATA,
      CSUM,
      FIN
   } ld_state_t;

endpackage

// File: rtl/prog_ram_16x8.sv
// Program RAM: synchronous write port, asynchronous read port, no reset.
module prog_ram_16x8 #(
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int ADDR_W = cpu_pkg::ADDR_W,
   parameter int DEPTH  = cpu_pkg::DEPTH
) (
   input  logic              CK,
   input  logic              WE,
   input  logic [ADDR_W-1:0] WA,
   input  logic [DATA_W-1:0] WD,
   input  logic [ADDR_W-1:0] AD,
   output logic [DATA_W-1:0] Q
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge CK) begin
      if (WE) mem[WA] <= WD;
   end

   assign Q = mem[AD];

endmodule

// File: rtl/prog_loader.sv
// Streams a program into the CPU program RAM and holds the CPU until done.
// Define PROG_LOADER_CSUM_EN to require a trailing checksum byte per session.
module prog_loader #(
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int ADDR_W = cpu_pkg::ADDR_W,
   parameter int DEPTH  = cpu_pkg::DEPTH
) (
   input  logic              CK,
   input  logic              RST,
   input  logic              START,
   input  logic [DATA_W-1:0] IN_DATA,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [ADDR_W-1:0] AD,
   output logic [DATA_W-1:0] Q,
   output logic              BUSY,
   output logic              CPU_HOLD,
   output logic              DONE,
   output logic              ERR
);

   import cpu_pkg::*;

   ld_state_t         state, state_nxt;
   logic [ADDR_W-1:0] addr, addr_nxt;
   logic [ADDR_W-1:0] cnt, cnt_nxt;
   logic              we;
   logic              xfer;

`ifdef PROG_LOADER_CSUM_EN
   logic [DATA_W-1:0] sum, sum_nxt;
   logic              err, err_nxt;
`endif

   assign IN_READY = (state == HDR) | (state == DATA) | (state == CSUM);
   assign BUSY     = IN_READY;
   assign CPU_HOLD = (state != FIN);
   assign DONE     = (state == FIN);
   assign xfer     = IN_VALID & IN_READY;

`ifdef PROG_LOADER_CSUM_EN
   assign ERR = err;
`else
   assign ERR = 1'b0;
`endif

   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         addr  <= '0;
         cnt   <= '0;
`ifdef PROG_LOADER_CSUM_EN
         sum   <= '0;
         err   <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         addr  <= addr_nxt;
         cnt   <= cnt_nxt;
`ifdef PROG_LOADER_CSUM_EN
         sum   <= sum_nxt;
         err   <= err_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      addr_nxt  = addr;
      cnt_nxt   = cnt;
      we        = 1'b0;
`ifdef PROG_LOADER_CSUM_EN
      sum_nxt   = sum;
      err_nxt   = err;
`endif
      unique case (state)
         IDLE, FIN: begin
            if (START) begin
               state_nxt = HDR;
`ifdef PROG_LOADER_CSUM_EN
               sum_nxt   = '0;
               err_nxt   = 1'b0;
`endif
            end
         end
         HDR: begin
            if (xfer) begin
               cnt_nxt   = IN_DATA[ADDR_W-1:0];
               addr_nxt  = '0;
               state_nxt = DATA;
`ifdef PROG_LOADER_CSUM_EN
               sum_nxt   = sum + IN_DATA;
`endif
            end
         end
         DATA: begin
            if (xfer) begin
               we = 1'b1;
`ifdef PROG_LOADER_CSUM_EN
               sum_nxt = sum + IN_DATA;
`endif
               // addr saturates at cnt, so a 0F header never wraps
               if (addr == cnt) begin
`ifdef PROG_LOADER_CSUM_EN
                  state_nxt = CSUM;
`else
                  state_nxt = FIN;
`endif
               end else begin
                  addr_nxt = addr + ADDR_W'(1);
               end
            end
         end
`ifdef PROG_LOADER_CSUM_EN
         CSUM: begin
            if (xfer) begin
               if (IN_DATA == sum) begin
                  state_nxt = FIN;
                  err_nxt   = 1'b0;
               end else begin
                  state_nxt = IDLE;
                  err_nxt   = 1'b1;
               end
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   prog_ram_16x8 #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .CK (CK),
      .WE (we),
      .WA (addr),
      .WD (IN_DATA),
      .AD (AD),
      .Q  (Q)
   );

endmodule
